bin2bcd_seq: RTL and testbench

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq_if.sv | 28 ++
 rtl/bin2bcd_seq.sv | 119 +++++++++++
 tb/tb_bin2bcd_seq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle for the sequential binary-to-BCD converter.
// The slave modport is the converter side; master is the requester side.
interface bin2bcd_seq_if #(
   parameter int unsigned W      = 8,
   parameter int unsigned DIGITS = 3
) ();
   logic                  i_start;
   logic [W-1:0]          i_bin;
   logic                  o_busy;
   logic                  o_done;
   logic [4*DIGITS-1:0]   o_bcd;

   modport slave (
      input  i_start,
      input  i_bin,
      output o_busy,
      output o_done,
      output o_bcd
   );

   modport master (
      output i_start,
      output i_bin,
      input  o_busy,
      input  o_done,
      input  o_bcd
   );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one shift-and-add-3
// iteration per clock, result registered and announced with a DONE pulse.
module bin2bcd_seq #(
   parameter int unsigned W      = 8,
   parameter int unsigned DIGITS = 3
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   bin2bcd_seq_if.slave   bus
);
   localparam int unsigned CW = $clog2(W + 1);
   localparam int unsigned BW = 4 * DIGITS;
   localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned p;
      p = 1;
      for (int unsigned i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   // Every W-bit value must fit in DIGITS decimal digits.
   if (pow10(DIGITS) <= ((longint'(1) << W) - 1)) begin : g_illegal_cfg
      $error("bin2bcd_seq: DIGITS too small for W");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_FINISH
   } state_t;

   state_t           r_state;
   state_t           w_next_state;
   logic [W-1:0]     r_shift;
   logic [BW-1:0]    r_scratch;
   logic [CW-1:0]    r_cnt;
   logic [BW-1:0]    r_bcd;
   logic             r_done;
   logic [BW-1:0]    w_adj;
   logic             w_busy;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_busy       = 1'b1;
      case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (bus.i_start) w_next_state = S_SHIFT;
         end
         S_SHIFT: begin
            if (r_cnt == LAST_CNT) w_next_state = S_FINISH;
         end
         S_FINISH: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
            w_busy       = 1'b0;
         end
      endcase
   end

   // Add-3 correction is applied to the digits before they are shifted.
   always_comb begin
      w_adj = '0;
      for (int unsigned d = 0; d < DIGITS; d++) begin
         if (r_scratch[4*d +: 4] >= 4'd5) begin
            w_adj[4*d +: 4] = r_scratch[4*d +: 4] + 4'd3;
         end else begin
            w_adj[4*d +: 4] = r_scratch[4*d +: 4];
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_shift   <= '0;
         r_scratch <= '0;
         r_cnt     <= '0;
         r_bcd     <= '0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.i_start) begin
                  r_shift   <= bus.i_bin;
                  r_scratch <= '0;
                  r_cnt     <= '0;
               end
            end
            S_SHIFT: begin
               {r_scratch, r_shift} <= {w_adj[BW-2:0], r_shift, 1'b0};
               r_cnt                <= r_cnt + CW'(1);
            end
            S_FINISH: begin
               r_bcd  <= r_scratch;
               r_done <= 1'b1;
            end
            default: begin
               r_done <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_busy = w_busy;
   assign bus.o_done = r_done;
   assign bus.o_bcd  = r_bcd;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed table-driven bench for bin2bcd_seq plus multi-cycle corner cases
// (ignored START, back-to-back start, mid-conversion reset, full sweep).
module tb_bin2bcd_seq;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_pass;

   bin2bcd_seq_if #(.W(8), .DIGITS(3)) bus ();

   bin2bcd_seq #(.W(8), .DIGITS(3)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  bin;
      logic [11:0] exp;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   function automatic logic [11:0] ref_bcd(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic logic digits_ok(input logic [11:0] b);
      return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (b[11:8] <= 4'd9);
   endfunction

   // Called #1 after a rising edge with the DUT idle.
   task automatic convert(input logic [7:0] b, input logic [11:0] exp, input string nm);
      int lat;
      int dones;
      int busy_lo;
      logic [11:0] got;
      bus.i_start = 1'b1;
      bus.i_bin   = b;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      bus.i_bin   = ~b;
      lat = 0; dones = 0; busy_lo = (bus.o_busy) ? 0 : 1;
      got = '0;
      for (int c = 1; c <= 12; c++) begin
         @(posedge clk); #1;
         if (bus.o_done) begin
            dones++;
            if (lat == 0) begin
               lat = c;
               got = bus.o_bcd;
            end
         end
         if (c < 9 && !bus.o_busy) busy_lo++;
      end
      check({nm, " latency"}, lat, 9);
      check({nm, " done_count"}, dones, 1);
      check({nm, " busy_gap"}, busy_lo, 0);
      check({nm, " bcd"}, {20'd0, got}, {20'd0, exp});
   endtask

   initial begin
      int dones;
      int lat;
      int busy_hi;
      n_checks = 0;
      n_pass   = 0;
      rst_n       = 1'b0;
      bus.i_start = 1'b1;
      bus.i_bin   = 8'd77;

      vecs[0] = '{8'd0,   12'h000};
      vecs[1] = '{8'd255, 12'h255};
      vecs[2] = '{8'd137, 12'h137};
      vecs[3] = '{8'd9,   12'h009};
      vecs[4] = '{8'd10,  12'h010};
      vecs[5] = '{8'd7,   12'h007};
      vecs[6] = '{8'd99,  12'h099};
      vecs[7] = '{8'd100, 12'h100};
      vecs[8] = '{8'd128, 12'h128};
      vecs[9] = '{8'd1,   12'h001};

      // START held during reset must not begin a conversion.
      repeat (3) @(posedge clk);
      #1;
      check("reset busy", {31'd0, bus.o_busy}, 0);
      check("reset done", {31'd0, bus.o_done}, 0);
      check("reset bcd", {20'd0, bus.o_bcd}, 0);
      bus.i_start = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("idle after reset busy", {31'd0, bus.o_busy}, 0);

      for (int i = 0; i < 10; i++) begin
         convert(vecs[i].bin, vecs[i].exp, $sformatf("vec%0d", i));
      end

      // START pulses during a conversion are ignored.
      bus.i_start = 1'b1;
      bus.i_bin   = 8'd200;
      @(posedge clk); #1;
      dones = 0; lat = 0; busy_hi = bus.o_busy ? 1 : 0;
      for (int c = 1; c <= 15; c++) begin
         if (c == 2 || c == 5) begin
            bus.i_start = 1'b1;
            bus.i_bin   = 8'd55;
         end else begin
            bus.i_start = 1'b0;
         end
         @(posedge clk); #1;
         if (bus.o_done) begin
            dones++;
            if (lat == 0) lat = c;
         end
         if (bus.o_busy) busy_hi++;
      end
      check("ignore done_count", dones, 1);
      check("ignore latency", lat, 9);
      check("ignore busy_cycles", busy_hi, 9);
      check("ignore bcd", {20'd0, bus.o_bcd}, 32'h200);

      // Back-to-back: START on the DONE cycle is accepted.
      bus.i_start = 1'b1;
      bus.i_bin   = 8'd99;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      lat = 0;
      for (int c = 1; c <= 15 && lat == 0; c++) begin
         @(posedge clk); #1;
         if (bus.o_done) lat = c;
      end
      check("b2b first latency", lat, 9);
      check("b2b first bcd", {20'd0, bus.o_bcd}, 32'h099);
      bus.i_start = 1'b1;
      bus.i_bin   = 8'd100;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      check("b2b second accepted", {31'd0, bus.o_busy}, 1);
      check("b2b done single", {31'd0, bus.o_done}, 0);
      check("b2b bcd held", {20'd0, bus.o_bcd}, 32'h099);
      lat = 0;
      for (int c = 1; c <= 15 && lat == 0; c++) begin
         @(posedge clk); #1;
         if (bus.o_done) lat = c;
      end
      check("b2b second latency", lat, 9);
      check("b2b second bcd", {20'd0, bus.o_bcd}, 32'h100);
      @(posedge clk); #1;

      // Mid-conversion reset aborts asynchronously with no DONE.
      bus.i_start = 1'b1;
      bus.i_bin   = 8'd255;
      @(posedge clk); #1;
      bus.i_start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("abort busy before", {31'd0, bus.o_busy}, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort busy", {31'd0, bus.o_busy}, 0);
      check("abort bcd", {20'd0, bus.o_bcd}, 0);
      bus.i_start = 1'b1;
      dones = 0;
      repeat (2) begin
         @(posedge clk); #1;
         if (bus.o_done) dones++;
      end
      bus.i_start = 1'b0;
      rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (bus.o_done || bus.o_busy) dones++;
      end
      check("abort no_done", dones, 0);
      check("abort bcd after", {20'd0, bus.o_bcd}, 0);
      convert(8'd42, 12'h042, "after_abort");

      // Exhaustive sweep against the arithmetic reference.
      for (int v = 0; v < 256; v++) begin
         logic [11:0] e;
         e = ref_bcd(v);
         convert(8'(v), e, $sformatf("sweep%0d", v));
         check($sformatf("sweep%0d digits", v), {31'd0, digits_ok(bus.o_bcd)}, 1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Absolute time bound so the bench always terminates.
   initial begin
      #2000000;
      $display("FAIL timeout: got %0d expected %0d checks", n_checks, 0);
      $display("%0d/%0d checks passed", n_pass, n_checks + 1);
      $finish;
   end
endmodule
